// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern stage: mode encoding, widths,
// the colour-bar palette and the fixed fill colours.
package vga_pkg;

  localparam int COLOR_W = 4;
  localparam int COORD_W = 11;
  localparam int RGB_W   = 3 * COLOR_W;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][RGB_W-1:0] BAR_COLORS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  localparam logic [RGB_W-1:0] RGB_WHITE  = 12'hFFF;
  localparam logic [RGB_W-1:0] RGB_BLACK  = 12'h000;
  localparam logic [RGB_W-1:0] RGB_GREY   = 12'h888;
  localparam logic [RGB_W-1:0] RGB_BOX_BG = 12'h004;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: advances bx/by once per frame tick and reverses an
// axis when the next step would leave the active area.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int BOX_SIZE      = 32,
  parameter int BOX_STEP      = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  output logic [COORD_W-1:0] bx_o,
  output logic [COORD_W-1:0] by_o
);

  localparam logic [COORD_W-1:0] STEP_C = COORD_W'(BOX_STEP);
  localparam logic [COORD_W-1:0] SIZE_C = COORD_W'(BOX_SIZE);

  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic               xneg_q, xneg_d, yneg_q, yneg_d;

  // Returns {negative_direction, position} after one step along an axis.
  function automatic logic [COORD_W:0] advance(input logic [COORD_W-1:0] pos,
                                               input logic neg,
                                               input logic [COORD_W-1:0] active);
    logic [COORD_W:0] res;
    if (!neg) begin
      if (pos + STEP_C + SIZE_C >= active) res = {1'b1, active - SIZE_C};
      else                                 res = {1'b0, pos + STEP_C};
    end else begin
      if (pos < STEP_C) res = {1'b0, {COORD_W{1'b0}}};
      else              res = {1'b1, pos - STEP_C};
    end
    return res;
  endfunction

  // Next position: step on tick, hold otherwise.
  always_comb begin
    {xneg_d, bx_d} = tick_i ? advance(bx_q, xneg_q, COORD_W'(ACTIVE_WIDTH))
                            : {xneg_q, bx_q};
    {yneg_d, by_d} = tick_i ? advance(by_q, yneg_q, COORD_W'(ACTIVE_HEIGHT))
                            : {yneg_q, by_q};
  end

  // Position and direction registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bx_q   <= '0;
      by_q   <= '0;
      xneg_q <= 1'b0;
      yneg_q <= 1'b0;
    end else begin
      bx_q   <= bx_d;
      by_q   <= by_d;
      xneg_q <= xneg_d;
      yneg_q <= yneg_d;
    end
  end

  assign bx_o = bx_q;
  assign by_o = by_q;

endmodule

// File: rtl/vga_pattern.sv
// VGA test-pattern colour stage with a 2-cycle pipeline keeping syncs/de aligned.
// Define VGA_PATTERN_BOX_EN to build the bouncing box; otherwise mode 3 is flat grey.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int CHECKER_LOG2  = 5,
  parameter int BOX_SIZE      = 32,
  parameter int BOX_STEP      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               de_in,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [1:0]         mode_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic [7:0]         frame_cnt
);

  localparam int BAR_W = ACTIVE_WIDTH / 8;

  if (((ACTIVE_WIDTH % 8) != 0) || (BOX_SIZE + BOX_STEP > ACTIVE_HEIGHT)) begin : g_bad_cfg
    $error("vga_pattern: unsupported geometry parameters");
  end

  logic        tick_s;
  mode_e       mode_q, mode_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  bar_idx_s;

  logic        s1_hs_q, s1_vs_q, s1_de_q, s1_chk_q;
  logic [2:0]  s1_bar_q;
  logic [7:0]  s1_grad_q;

  logic             hsync_q, vsync_q, de_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  assign tick_s = (x == 11'd0) && (y == COORD_W'(ACTIVE_HEIGHT));

`ifdef VGA_PATTERN_BOX_EN
  localparam logic [COORD_W-1:0] BOX_SIZE_C = COORD_W'(BOX_SIZE);
  logic [COORD_W-1:0] bx_s, by_s;
  logic               box_hit_s, s1_box_q;

  vga_box_mover #(
    .ACTIVE_WIDTH (ACTIVE_WIDTH),
    .ACTIVE_HEIGHT(ACTIVE_HEIGHT),
    .BOX_SIZE     (BOX_SIZE),
    .BOX_STEP     (BOX_STEP)
  ) u_box (
    .clk_i (clk),
    .rst_i (rst),
    .tick_i(tick_s),
    .bx_o  (bx_s),
    .by_o  (by_s)
  );

  assign box_hit_s = (x >= bx_s) && (x < bx_s + BOX_SIZE_C) &&
                     (y >= by_s) && (y < by_s + BOX_SIZE_C);

  // Stage 1 box-hit term.
  always_ff @(posedge clk) begin
    if (rst) s1_box_q <= 1'b0;
    else     s1_box_q <= box_hit_s;
  end
`endif

  // Bar index counts the boundaries already passed, so no divider is needed.
  always_comb begin
    bar_idx_s = 3'd0;
    for (int i = 1; i < 8; i++) begin
      bar_idx_s = bar_idx_s + 3'(x >= COORD_W'(i * BAR_W));
    end
  end

  // Per-frame state advances only on the tick, which sits in vertical blanking.
  always_comb begin
    if (tick_s) begin
      mode_d      = mode_e'(mode_sel);
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_BARS;
      frame_cnt_q <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Stage 1: timing and per-mode terms.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_chk_q  <= 1'b0;
      s1_bar_q  <= 3'd0;
      s1_grad_q <= 8'd0;
    end else begin
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      s1_de_q   <= de_in;
      s1_chk_q  <= x[CHECKER_LOG2] ^ y[CHECKER_LOG2];
      s1_bar_q  <= bar_idx_s;
      s1_grad_q <= {x[9:6], y[8:5]};
    end
  end

  // Colour mux; blanking overrides every mode.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (s1_de_q) begin
      case (mode_q)
        MODE_BARS:     rgb_d = BAR_COLORS[s1_bar_q];
        MODE_CHECKER:  rgb_d = s1_chk_q ? RGB_WHITE : RGB_BLACK;
        MODE_GRADIENT: rgb_d = {s1_grad_q, frame_cnt_q[7:4]};
`ifdef VGA_PATTERN_BOX_EN
        MODE_BOX:      rgb_d = s1_box_q ? RGB_WHITE : RGB_BOX_BG;
`else
        MODE_BOX:      rgb_d = RGB_GREY;
`endif
        default:       rgb_d = RGB_BLACK;
      endcase
    end else begin
      rgb_d = RGB_BLACK;
    end
  end

  // Stage 2: aligned output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= s1_hs_q;
      vsync_q <= s1_vs_q;
      de_q    <= s1_de_q;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign r         = rgb_q[RGB_W-1 -: COLOR_W];
  assign g         = rgb_q[COLOR_W +: COLOR_W];
  assign b         = rgb_q[COLOR_W-1:0];
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_pattern.md
# vga_pattern

Pixel-colour stage fed directly by the VGA timing generator. Consumes raster coordinates, `de` and syncs, and produces 4-bit-per-channel RGB. The test pattern is selectable per frame: colour bars, checkerboard, animated gradient, or a bouncing box. Syncs and `de` are re-registered alongside the colour pipeline so all outputs leave aligned to the DAC/connector.

## Interface
Parameters:
- `ACTIVE_WIDTH`, 640: visible pixels per line; must be a multiple of 8.
- `ACTIVE_HEIGHT`, 480: visible lines per frame.
- `CHECKER_LOG2`, 5: checker square edge is 2^CHECKER_LOG2 pixels.
- `BOX_SIZE`, 32: bouncing-box edge in pixels.
- `BOX_STEP`, 2: box displacement per frame per axis.

Ports:
- `clk`  in  1  pixel clock, 25.175 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `hsync_in`, `vsync_in`  in  1 each  syncs from the timing generator.
- `de_in`  in  1  active-area flag from the timing generator.
- `x`, `y`  in  11 each  raster coordinates from the timing generator.
- `mode_sel`  in  2  requested pattern: 0 bars, 1 checker, 2 gradient, 3 box.
- `hsync`, `vsync`, `de`  out  1 each  delayed copies of the inputs.
- `r`, `g`, `b`  out  4 each  pixel colour.
- `frame_cnt`  out  8  frames since reset.

## Operation
- **Frame tick:** a one-cycle internal pulse when `x == 0 && y == ACTIVE_HEIGHT`. This point is in vertical blanking, so every visible pixel of a frame uses one consistent state.
- **On tick:**
  - `mode_sel` is latched into `mode_q`.
  - `frame_cnt` increments, wrapping from 255 to 0.
  - The box position updates.
- **Between ticks:** `mode_sel` changes have no effect.
- **Mode 0, bars:** eight bars, each `ACTIVE_WIDTH/8` pixels wide. The bar index is found with a comparator chain, not a divider. Colours left to right: white, yellow, cyan, green, magenta, red, blue, black. "On" channels are 4'hF; "off" channels are 0.
- **Mode 1, checker:** white (FFF) when `x[CHECKER_LOG2] ^ y[CHECKER_LOG2]` is 1, otherwise black.
- **Mode 2, gradient:** `r = x[9:6]`, `g = y[8:5]`, `b = frame_cnt[7:4]`.
- **Mode 3, box:**
  - White (FFF) inside `bx <= x < bx+BOX_SIZE` and `by <= y < by+BOX_SIZE`.
  - Background elsewhere: `r = 0`, `g = 0`, `b = 4`.
- **Box motion, X axis** (Y axis identical, using `ACTIVE_HEIGHT`):
  - Moving positive: if `bx + BOX_STEP + BOX_SIZE >= ACTIVE_WIDTH`, set `bx = ACTIVE_WIDTH - BOX_SIZE` and reverse direction. Otherwise `bx += BOX_STEP`.
  - Moving negative: if `bx < BOX_STEP`, set `bx = 0` and reverse direction. Otherwise `bx -= BOX_STEP`.
  - The box moves on every tick regardless of `mode_q`.
- **Blanking:** whenever the output `de` is 0, `r`, `g` and `b` are forced to 0 in every mode.
- **Arithmetic:** 11-bit unsigned, matching the coordinate width. Coordinates in blanking are never used for colour.

## Timing
- **Latency:** exactly 2 cycles. Outputs at cycle n+2 correspond to inputs at cycle n.
- **Pipeline stages:**
  - Stage 1 registers the inputs and the per-mode hit/index terms.
  - Stage 2 registers the colour mux plus `hsync`, `vsync` and `de`.
- **Sync alignment:** `hsync`, `vsync` and `de` pass through unmodified, delayed 2 cycles, with the same delay as the RGB.
- **Reset values:** all outputs are 0, as are all pipeline registers. Also `mode_q = 0`, `bx = by = 0`, box direction +X/+Y, `frame_cnt = 0`.
- **Reset mid-frame:** every state is reinitialised on the next edge, with no partial-frame state kept. The first tick after release latches the mode.
- **Simultaneous events:** a tick and a `mode_sel` change in the same cycle latch the new `mode_sel`.

## Configuration
- **`VGA_PATTERN_BOX_EN` defined:** the box mover and mode 3 are implemented as described above.
- **`VGA_PATTERN_BOX_EN` undefined:**
  - No box registers or box logic exist.
  - Mode 3 outputs flat mid-grey (`r = g = b = 8`) during `de`.
  - All other modes and latency are unchanged.

## Structure
- **Shared package `vga_pkg`:**
  - Mode encoding constants `MODE_BARS`, `MODE_CHECKER`, `MODE_GRADIENT`, `MODE_BOX`.
  - Colour width (4).
  - Coordinate width (11).
  - The 8-entry bar colour constants.
- **Sub-module `vga_box_mover`:** holds `bx`, `by` and their direction bits, and advances them on the frame tick. It is instantiated only under `VGA_PATTERN_BOX_EN`.

## Test plan
- **Reset latency:** hold `rst` high for 3 cycles, then feed timing from the generator. All outputs stay 0 through reset, and output `hsync` equals `hsync_in` delayed by exactly 2 cycles.
- **Bars:** `mode_sel = 0`, run one tick, then sample line 100 at x = 0, 80, 320 and 639. Expected RGB: FFF, FF0, F0F, 000.
- **Checker:** `mode_sel = 1`, default parameters. Pixel (0,0) → 000, (32,0) → FFF, (32,32) → 000.
- **Mode latching:** switch `mode_sel` from 0 to 2 mid-frame (y = 200). The rest of that frame stays bars; the next frame is gradient, with pixel (64,32) → r = 1, g = 1.
- **Box bounce:** `mode_sel = 3`, run 304 frames. Then `bx = 608`, `by = 448` (the Y axis reverses at frame 224), and the X direction is negative. Frame 305 gives `bx = 606`.
- **Blanking and config:** any pixel with `de_in = 0` → RGB 000. With the macro undefined, mode 3 pixel (10,10) → 888.
